// File: rtl/cnn_mac_pkg.sv
// Shared helpers for the CNN multiply-accumulate pipeline: the accumulator sizing rule
// and the round/shift/saturate step applied to each finished sum.
package cnn_mac_pkg;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } rnd_sat_t;

    function automatic int min_acc_width(input int a_width, input int b_width, input int num_taps);
        return a_width + b_width + $clog2(num_taps);
    endfunction

    // Round half toward +inf, arithmetic shift, then clamp to a signed out_width range.
    function automatic rnd_sat_t round_sat(input logic [63:0] acc, input int acc_width,
                                           input int frac_shift, input int out_width);
        logic signed [63:0] accExt;
        logic signed [63:0] bias;
        logic signed [63:0] shifted;
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        rnd_sat_t           res;
        accExt  = $signed(acc << (64 - acc_width)) >>> (64 - acc_width);
        bias    = (frac_shift > 0) ? (64'sd1 <<< (frac_shift - 1)) : 64'sd0;
        shifted = (accExt + bias) >>> frac_shift;
        maxVal  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        minVal  = -(64'sd1 <<< (out_width - 1));
        res.value = shifted;
        res.sat   = 1'b0;
        if (shifted > maxVal) begin
            res.value = maxVal;
            res.sat   = 1'b1;
        end else if (shifted < minVal) begin
            res.value = minVal;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnn_mac_pipe_if.sv
// Sample-in / result-out valid-ready bus of the MAC pipeline.
interface cnn_mac_pipe_if #(
    parameter int A_WIDTH   = 14,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_WIDTH-1:0]   in_a;
    logic        [B_WIDTH-1:0]   in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/cnn_mac_mul_pipe.sv
// Signed x zero-extended-unsigned multiplier: operand registers, then MUL_STAGES product
// registers, laid out as A/B -> M -> P so the tools can fold it into one DSP slice.
module cnn_mac_mul_pipe #(
    parameter  int A_WIDTH    = 14,
    parameter  int B_WIDTH    = 8,
    parameter  int MUL_STAGES = 2,
    localparam int P_WIDTH    = A_WIDTH + B_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic                      i_valid,
    input  logic signed [A_WIDTH-1:0] i_a,
    input  logic        [B_WIDTH-1:0] i_b,
    output logic                      o_valid,
    output logic signed [P_WIDTH-1:0] o_prod
);
    logic signed [A_WIDTH-1:0] r_a;
    logic        [B_WIDTH-1:0] r_b;
    logic                      r_opValid;
    logic signed [P_WIDTH-1:0] r_prod  [MUL_STAGES];
    logic                      r_valid [MUL_STAGES];
    logic signed [P_WIDTH-1:0] w_prod;

    assign w_prod  = r_a * $signed({1'b0, r_b});
    assign o_valid = r_valid[MUL_STAGES-1];
    assign o_prod  = r_prod[MUL_STAGES-1];

    // A clear drops only the valid bits; stale data is harmless once invalidated.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_opValid <= 1'b0;
            for (int s = 0; s < MUL_STAGES; s++) begin
                r_prod[s]  <= '0;
                r_valid[s] <= 1'b0;
            end
        end else begin
            if (i_en) begin
                r_a       <= i_a;
                r_b       <= i_b;
                r_prod[0] <= w_prod;
                for (int s = 1; s < MUL_STAGES; s++) begin
                    r_prod[s] <= r_prod[s-1];
                end
            end
            if (i_clr) begin
                r_opValid <= 1'b0;
                for (int s = 0; s < MUL_STAGES; s++) begin
                    r_valid[s] <= 1'b0;
                end
            end else if (i_en) begin
                r_opValid  <= i_valid;
                r_valid[0] <= r_opValid;
                for (int s = 1; s < MUL_STAGES; s++) begin
                    r_valid[s] <= r_valid[s-1];
                end
            end
        end
    end
endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed x unsigned MAC: accumulates NUM_TAPS products per result, then
// rounds, shifts and saturates into a one-entry output register behind valid/ready.
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter int A_WIDTH    = 14,
    parameter int B_WIDTH    = 8,
    parameter int NUM_TAPS   = 9,
    parameter int MUL_STAGES = 2,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          soft_clr,
    cnn_mac_pipe_if.slave bus
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int TAP_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    if (NUM_TAPS < 1 || MUL_STAGES < 1) begin : g_paramCheck
        $error("cnn_mac_pipe: NUM_TAPS and MUL_STAGES must be at least 1");
    end
    if (ACC_WIDTH < min_acc_width(A_WIDTH, B_WIDTH, NUM_TAPS) || ACC_WIDTH > 63) begin : g_accWidthCheck
        $error("cnn_mac_pipe: ACC_WIDTH cannot hold a full group of products");
    end

    logic                        w_adv;
    logic                        w_accept;
    logic                        w_mulValid;
    logic signed [P_WIDTH-1:0]   w_mulProd;
    logic signed [ACC_WIDTH-1:0] w_prodExt;
    logic                        w_lastTap;
    rnd_sat_t                    w_rs;
    logic                        w_unusedRsBits;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [TAP_W-1:0]     r_tap;
    logic                        r_accDone;
    logic                        r_outValid;
    logic signed [OUT_WIDTH-1:0] r_outData;
    logic                        r_outSat;

    // One global advance enable: everything moves unless a held result is blocking.
    assign w_adv         = !r_outValid || bus.out_ready;
    assign bus.in_ready  = w_adv && ap_rst_n;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_sat   = r_outSat;

    cnn_mac_mul_pipe #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .MUL_STAGES(MUL_STAGES)
    ) u_mul (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .i_en    (w_adv),
        .i_clr   (soft_clr),
        .i_valid (w_accept),
        .i_a     (bus.in_a),
        .i_b     (bus.in_b),
        .o_valid (w_mulValid),
        .o_prod  (w_mulProd)
    );

    assign w_prodExt      = ACC_WIDTH'(w_mulProd);
    assign w_lastTap      = (r_tap == TAP_W'(NUM_TAPS - 1));
    assign w_rs           = round_sat(64'(r_acc), ACC_WIDTH, FRAC_SHIFT, OUT_WIDTH);
    assign w_unusedRsBits = ^w_rs.value[63:OUT_WIDTH];

    // Tap 0 loads the accumulator so no separate clear is needed between groups.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc     <= '0;
            r_tap     <= '0;
            r_accDone <= 1'b0;
        end else if (soft_clr) begin
            r_tap     <= '0;
            r_accDone <= 1'b0;
        end else if (w_adv) begin
            r_accDone <= w_mulValid && w_lastTap;
            if (w_mulValid) begin
                r_acc <= (r_tap == '0) ? w_prodExt : r_acc + w_prodExt;
                r_tap <= w_lastTap ? '0 : r_tap + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSat   <= 1'b0;
        end else if (soft_clr) begin
            r_outValid <= 1'b0;
            r_outSat   <= 1'b0;
        end else if (w_adv) begin
            r_outValid <= r_accDone;
            if (r_accDone) begin
                r_outData <= w_rs.value[OUT_WIDTH-1:0];
                r_outSat  <= w_rs.sat;
            end
        end
    end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Scoreboard bench for cnn_mac_pipe: a 9-tap instance plus a 1-tap instance,
// expected results queued at stimulus time and popped on each output transfer.
module tb_cnn_mac_pipe;

    typedef struct {
        logic signed [15:0] data;
        logic               sat;
    } exp_t;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    logic soft_clr = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t sbQ[$];
    exp_t sbQ1[$];

    always #5 ap_clk = ~ap_clk;

    cnn_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(8), .OUT_WIDTH(16)) bus  ();
    cnn_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(8), .OUT_WIDTH(16)) bus1 ();

    cnn_mac_pipe dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .soft_clr(soft_clr),
        .bus     (bus)
    );

    cnn_mac_pipe #(.NUM_TAPS(1)) dut1 (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .soft_clr(soft_clr),
        .bus     (bus1)
    );

    function automatic exp_t modelResult(input longint sum);
        exp_t   e;
        longint r;
        r = (sum + 64'sd128) >>> 8;
        if (r > 32767) begin
            e.data = 16'sh7FFF;
            e.sat  = 1'b1;
        end else if (r < -32768) begin
            e.data = 16'sh8000;
            e.sat  = 1'b1;
        end else begin
            e.data = 16'(r);
            e.sat  = 1'b0;
        end
        return e;
    endfunction

    function automatic longint prod(input logic signed [13:0] a, input logic [7:0] b);
        return longint'(a) * longint'(b);
    endfunction

    // Monitor for the 9-tap unit: handshake rule, hold stability, scoreboard pop.
    logic               prevStall = 1'b0;
    logic signed [15:0] heldData;
    logic               heldSat;
    always @(negedge ap_clk) begin
        exp_t e;
        testsRun++;
        if (bus.in_ready !== (ap_rst_n && !(bus.out_valid && !bus.out_ready))) begin
            testsFailed++;
            $display("[TB] FAIL in_ready_rule: in_ready=%b while out_valid=%b out_ready=%b rst_n=%b",
                     bus.in_ready, bus.out_valid, bus.out_ready, ap_rst_n);
        end
        if (ap_rst_n && prevStall && bus.out_valid) begin
            testsRun++;
            if (bus.out_data !== heldData || bus.out_sat !== heldSat) begin
                testsFailed++;
                $display("[TB] FAIL hold_stable: got %0d/%b, held %0d/%b",
                         bus.out_data, bus.out_sat, heldData, heldSat);
            end
        end
        prevStall = ap_rst_n && bus.out_valid && !bus.out_ready;
        heldData  = bus.out_data;
        heldSat   = bus.out_sat;
        if (ap_rst_n && bus.out_valid && bus.out_ready) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_result: got %0d sat=%b, nothing expected",
                         bus.out_data, bus.out_sat);
            end else begin
                e = sbQ.pop_front();
                if (bus.out_data !== e.data || bus.out_sat !== e.sat) begin
                    testsFailed++;
                    $display("[TB] FAIL result: got %0d sat=%b, expected %0d sat=%b",
                             bus.out_data, bus.out_sat, e.data, e.sat);
                end
            end
        end
    end

    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst_n && bus1.out_valid && bus1.out_ready) begin
            testsRun++;
            if (sbQ1.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_result_1tap: got %0d, nothing expected", bus1.out_data);
            end else begin
                e = sbQ1.pop_front();
                if (bus1.out_data !== e.data || bus1.out_sat !== e.sat) begin
                    testsFailed++;
                    $display("[TB] FAIL result_1tap: got %0d sat=%b, expected %0d sat=%b",
                             bus1.out_data, bus1.out_sat, e.data, e.sat);
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic driveTap(input bit single, input logic signed [13:0] a, input logic [7:0] b);
        int waited = 0;
        bit taken  = 1'b0;
        if (single) begin
            bus1.in_valid = 1'b1; bus1.in_a = a; bus1.in_b = b;
        end else begin
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        end
        while (!taken) begin
            @(negedge ap_clk);
            taken = single ? (bus1.in_ready === 1'b1) : (bus.in_ready === 1'b1);
            @(posedge ap_clk);
            #1;
            if (!taken) begin
                waited++;
                if (waited > 200) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1",
                             single ? bus1.in_ready : bus.in_ready, waited);
                    break;
                end
            end
        end
        if (single) bus1.in_valid = 1'b0;
        else        bus.in_valid  = 1'b0;
    endtask

    task automatic pushExp(input logic signed [15:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sbQ.push_back(e);
    endtask

    task automatic repeatGroup(input logic signed [13:0] a, input logic [7:0] b,
                               input logic signed [15:0] d, input logic s);
        pushExp(d, s);
        for (int t = 0; t < 9; t++) driveTap(1'b0, a, b);
    endtask

    task automatic oneTapGroup(input logic signed [13:0] a, input logic [7:0] b,
                               input logic signed [15:0] d);
        pushExp(d, 1'b0);
        driveTap(1'b0, a, b);
        for (int t = 1; t < 9; t++) driveTap(1'b0, 14'sd0, 8'd0);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((sbQ.size() != 0 || sbQ1.size() != 0) && guard < 300) begin
            idleCycles(1);
            guard++;
        end
        testsRun++;
        if (sbQ.size() != 0 || sbQ1.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d/%0d results outstanding, required 0/0", sbQ.size(), sbQ1.size());
        end
        idleCycles(5);
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        idleCycles(3);
        @(negedge ap_clk);
        testsRun += 4;
        if (bus.in_ready !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
        end
        if (bus.out_data !== 16'sd0) begin
            testsFailed++; $display("[TB] FAIL reset_out_data: got %0d, expected 0", bus.out_data);
        end
        if (bus.out_sat !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_out_sat: got %b, expected 0", bus.out_sat);
        end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        idleCycles(2);
    endtask

    task automatic test_basic_group();
        repeatGroup(14'sd256, 8'd1, 16'sd9, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idleCycles(1);
            testsRun++;
            if (bus.out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL latency_early: out_valid=%b at edge %0d after last accept, expected 0",
                         bus.out_valid, k);
            end
        end
        idleCycles(1);
        testsRun++;
        if (bus.out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL latency_edge4: out_valid=%b at edge 4 after last accept, expected 1", bus.out_valid);
        end
        waitDrain();
    endtask

    task automatic test_rounding();
        oneTapGroup(14'sd1, 8'd128, 16'sd1);
        oneTapGroup(-14'sd1, 8'd128, 16'sd0);
        oneTapGroup(-14'sd1, 8'd129, -16'sd1);
        waitDrain();
    endtask

    task automatic test_saturation();
        repeatGroup(14'sh2000, 8'd255, 16'sh8000, 1'b1);
        repeatGroup(14'sd8191, 8'd255, 16'sh7FFF, 1'b1);
        waitDrain();
    endtask

    task automatic test_backpressure();
        logic signed [13:0] aList [36];
        logic        [7:0]  bList [36];
        longint             sum;
        for (int g = 0; g < 4; g++) begin
            sum = 0;
            for (int t = 0; t < 9; t++) begin
                aList[g*9+t] = 14'($urandom_range(0, 16383));
                bList[g*9+t] = 8'($urandom_range(0, 255));
                sum += prod(aList[g*9+t], bList[g*9+t]);
            end
            sbQ.push_back(modelResult(sum));
        end
        fork
            begin
                for (int i = 0; i < 36; i++) driveTap(1'b0, aList[i], bList[i]);
            end
            begin
                idleCycles(12);
                bus.out_ready = 1'b0;
                idleCycles(10);
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();
    endtask

    task automatic test_bubbles();
        logic signed [13:0] a;
        logic        [7:0]  b;
        longint             sum;
        for (int g = 0; g < 3; g++) begin
            sum = 0;
            for (int t = 0; t < 9; t++) begin
                a = 14'($urandom_range(0, 16383));
                b = 8'($urandom_range(0, 255));
                sum += prod(a, b);
                if (t == 8) sbQ.push_back(modelResult(sum));
                driveTap(1'b0, a, b);
                idleCycles($urandom_range(0, 3));
            end
        end
        for (int k = 0; k < 6; k++) begin
            a = 14'($urandom_range(0, 16383));
            b = 8'($urandom_range(0, 255));
            sbQ1.push_back(modelResult(prod(a, b)));
            driveTap(1'b1, a, b);
            idleCycles($urandom_range(0, 2));
        end
        waitDrain();
    endtask

    task automatic test_reset_mid_group();
        for (int t = 0; t < 5; t++) driveTap(1'b0, 14'sd256, 8'd1);
        ap_rst_n = 1'b0;
        idleCycles(2);
        ap_rst_n = 1'b1;
        idleCycles(8);
        repeatGroup(14'sd256, 8'd1, 16'sd9, 1'b0);
        waitDrain();
    endtask

    task automatic test_soft_clr_mid_group();
        for (int t = 0; t < 5; t++) driveTap(1'b0, 14'sd256, 8'd1);
        soft_clr = 1'b1;
        idleCycles(1);
        soft_clr = 1'b0;
        idleCycles(8);
        repeatGroup(14'sd256, 8'd1, 16'sd9, 1'b0);
        waitDrain();
    endtask

    task automatic test_clr_coincident();
        soft_clr = 1'b1;
        driveTap(1'b0, 14'sd5000, 8'd200);
        soft_clr = 1'b0;
        repeatGroup(14'sd256, 8'd1, 16'sd9, 1'b0);
        waitDrain();
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.out_ready = 1'b1;
        test_reset();
        test_basic_group();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid_group();
        test_soft_clr_mid_group();
        test_clr_coincident();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Pipelined, parametrised signed × unsigned multiply-accumulate unit for the CNN fixed-point datapath, replacing the single-cycle combinational 14s × 8u multiplier. It multiplies a signed weight by an unsigned activation, accumulates `NUM_TAPS` products per output, rounds and shifts to the output fixed-point format, and saturates the result. Input and output use valid/ready handshakes. It sits between the line-buffer/weight fetch logic and the per-layer output buffer of each conv stage.

## Interface
- `A_WIDTH`, default 14: signed weight width.
- `B_WIDTH`, default 8: unsigned activation width.
- `NUM_TAPS`, default 9: number of products accumulated per result (≥1); a value of 1 gives a plain pipelined multiplier.
- `MUL_STAGES`, default 2: register stages in the multiplier (≥1).
- `ACC_WIDTH`, default 32: accumulator width.
  - Elaboration fails if it is below `A_WIDTH + B_WIDTH + clog2(NUM_TAPS)`.
- `FRAC_SHIFT`, default 8: arithmetic right shift applied to the final sum (0 means no shift and no rounding).
- `OUT_WIDTH`, default 16: signed result width.

Ports:
- `ap_clk`, in, 1: clock. All state changes on the rising edge.
- `ap_rst_n`, in, 1: reset, asynchronous, active-low.
- `soft_clr`, in, 1: synchronous clear. Drops the partial group and all in-flight data.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: the unit can accept a sample.
- `in_a`, in, `A_WIDTH`: signed weight.
- `in_b`, in, `B_WIDTH`: unsigned activation, zero-extended before the multiply.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, `OUT_WIDTH`: signed result.
- `out_sat`, out, 1: qualifies `out_data`. High when the result was clipped.

## Operation
- **Transfer rules:**
  - An input transfer occurs on an edge with `in_valid && in_ready`.
  - An output transfer occurs on an edge with `out_valid && out_ready`.
- **Product:** `$signed(in_a) * $signed({1'b0,in_b})`, `A_WIDTH+B_WIDTH` bits, sign-extended into the accumulator.
- **Tap counter:** runs 0..`NUM_TAPS-1`. It increments when a product enters the accumulator and wraps to 0 after the last tap.
  - On tap 0 the accumulator is loaded with the product, not added to.
- **Result on the last tap:**
  - `r = (acc + (FRAC_SHIFT ? 1<<(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT`, which rounds half toward +∞.
  - `r` is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - `out_sat = 1` when the clamp is applied.
  - The clamped value is written into a one-entry output register.
- **Stall model:** a single global advance enable, `adv = !out_valid || out_ready`.
  - All pipeline registers, the accumulator and the counter update only when `adv` is high.
  - `in_ready = adv`, so `in_ready` depends combinationally on `out_ready`.
  - Bubbles (no input transfer) advance through the pipeline and do not modify the accumulator or the counter.
- **`soft_clr`:**
  - Clears pipeline valid bits, the tap counter, `out_valid` and `out_sat` on the next edge.
  - Has priority over a simultaneous input transfer; that sample is discarded.
  - Does not clear data registers.
- **Reset:** `ap_rst_n` low gives `in_ready = 0`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`, counter 0, accumulator 0, all stage valids 0.
  - Asserting it mid-group discards the group.
  - The first sample accepted after release is tap 0.

## Timing
- **Latency:** with no stall, `out_valid` rises `MUL_STAGES+2` edges after the edge that accepted the last tap (4 with defaults).
  - `MUL_STAGES` edges for the multiplier, 1 for the accumulate, 1 for round/saturate into the output register.
- **Throughput:** one sample per cycle while `out_ready` is high, i.e. one result per `NUM_TAPS` cycles.
- **Holding:** `out_data` and `out_sat` hold stable while `out_valid && !out_ready`.
- **Back-to-back groups:** a new result may enter the output register on the same edge the previous result transfers out.

## Structure
- Package `cnn_mac_pkg` holds:
  - the minimum accumulator width function (clog2-based), used for the elaboration check;
  - the round/shift/saturate function, parametrised by `ACC_WIDTH`, `FRAC_SHIFT` and `OUT_WIDTH`.
- Sub-module `cnn_mac_mul_pipe`:
  - `MUL_STAGES`-deep signed × zero-extended-unsigned multiplier with valid pipe and enable;
  - register layout chosen so the tools retime it into a single DSP48.
- The top level contains the tap counter, accumulator, round/saturate stage, output register and handshake.

## Test plan
All scenarios use default parameters unless stated.
- **Basic group:** 9 taps of a=256, b=1 streamed continuously → single result `out_data = 9` (2304+128 = 2432, >>8 = 9), `out_sat = 0`, `out_valid` 4 edges after the last accept.
- **Rounding:**
  - tap0 a=1, b=128, other taps 0 → `out_data = 1`;
  - tap0 a=-1, b=128, other taps 0 → `out_data = 0`;
  - tap0 a=-1, b=129, other taps 0 → `out_data = -1`.
- **Saturation:**
  - 9 taps a=-8192, b=255 → `out_data = -32768`, `out_sat = 1`;
  - 9 taps a=8191, b=255 → `out_data = 32767`, `out_sat = 1`.
- **Backpressure:** 4 back-to-back groups with `out_ready` low for 10 cycles mid-stream → `in_ready` low exactly while `out_valid && !out_ready`; all 4 results emerge in order and match the reference model; `out_data` stable while stalled.
- **Bubbles and wrap:** groups with random `in_valid` gaps and `NUM_TAPS = 1` and `NUM_TAPS = 9` builds → results match the model; the counter wraps with no tap lost or duplicated.
- **Reset and clear mid-group:**
  - `ap_rst_n` pulsed low after 5 taps → no `out_valid` from the partial group; the next 9 taps a=256, b=1 give 9.
  - `soft_clr` after 5 taps → same behaviour as the reset case.
  - `soft_clr` coincident with an accept → that sample is discarded.
